// File: rtl/ysyx_22040759_ctrl_fsm_if.sv
// ysyx_22040759_ctrl_fsm_if: handshake and datapath control bundle between IFU/datapath and the control FSM
// master: the control FSM (drives inst_ready and all datapath control lines)
// slave : IFU/ALU/LSU side (drives inst_valid, inst, br_taken, alu_done, mem_ack)
interface ysyx_22040759_ctrl_fsm_if;
  logic        inst_valid;
  logic [31:0] inst;
  logic        inst_ready;
  logic        br_taken;
  logic        alu_done;
  logic        mem_ack;
  logic [2:0]  immsel;
  logic [4:0]  alusel;
  logic        alu_word;
  logic        alu_start;
  logic        asel;
  logic        bsel;
  logic        mem_req;
  logic        mem_we;
  logic [2:0]  mem_size;
  logic [1:0]  wbsel;
  logic        regwen;
  logic        pc_wen;
  logic [1:0]  pc_sel;
  logic        halt;
  logic        illegal;
  modport master (
    input  inst_valid, inst, br_taken, alu_done, mem_ack,
    output inst_ready, immsel, alusel, alu_word, alu_start, asel, bsel,
           mem_req, mem_we, mem_size, wbsel, regwen, pc_wen, pc_sel, halt, illegal
  );
  modport slave (
    output inst_valid, inst, br_taken, alu_done, mem_ack,
    input  inst_ready, immsel, alusel, alu_word, alu_start, asel, bsel,
           mem_req, mem_we, mem_size, wbsel, regwen, pc_wen, pc_sel, halt, illegal
  );
endinterface

// File: rtl/ysyx_22040759_ctrl_fsm.sv
// ysyx_22040759_ctrl_fsm: multi-cycle RV32I/RV64I(+M) control unit sequencing FETCH/DECODE/EXEC/MEM/WB
// clk, rst : rising-edge clock, synchronous active-high reset
// bus      : master side of ysyx_22040759_ctrl_fsm_if
//            in : inst_valid, inst, br_taken, alu_done, mem_ack
//            out: inst_ready, immsel, alusel, alu_word, alu_start, asel, bsel, mem_req, mem_we,
//                 mem_size, wbsel, regwen, pc_wen, pc_sel, halt, illegal
module ysyx_22040759_ctrl_fsm #(
  parameter int XLEN  = 64,
  parameter bit HAS_M = 1'b1
) (
  input logic                      clk,
  input logic                      rst,
  ysyx_22040759_ctrl_fsm_if.master bus
);
  localparam logic [2:0] FETCH  = 3'd0;
  localparam logic [2:0] DECODE = 3'd1;
  localparam logic [2:0] EXEC   = 3'd2;
  localparam logic [2:0] MEM    = 3'd3;
  localparam logic [2:0] WB     = 3'd4;
  localparam logic [2:0] TRAP   = 3'd5;
  localparam bit RV64 = XLEN == 64;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BR     = 7'b1100011;
  localparam logic [6:0] OP_LD     = 7'b0000011;
  localparam logic [6:0] OP_ST     = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_IMM32  = 7'b0011011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_REG32  = 7'b0111011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_SYS    = 7'b1110011;
  localparam logic [31:0] EBREAK   = 32'h0010_0073;

  logic [2:0]  state_q, state_d;
  logic [31:0] ir_q, ir_d;
  logic        br_q, br_d;
  logic        illegal_q, illegal_d;
  logic        started_q, started_d;

  logic [6:0] op, f7;
  logic [2:0] f3;
  logic       shift, sh_ok, sh32_ok, r_ok;
  logic       legal, ebrk, is_m, is_ld, is_st, is_br, is_jal, is_jalr, is_fence;
  logic [2:0] imm_sel;
  logic [4:0] alu_sel;
  logic       word, a_pc, b_imm;
  logic [1:0] wb_sel;
  logic       dec_en, exec_done;

  assign op    = ir_q[6:0];
  assign f3    = ir_q[14:12];
  assign f7    = ir_q[31:25];
  assign shift = f3[1:0] == 2'b01;
  // RV64 shift-imm uses a 6-bit shamt, so ir[25] belongs to the shift amount there
  assign sh_ok   = RV64 ? (ir_q[31:26] == 6'd0 || (f3[2] && ir_q[31:26] == 6'h10))
                        : (f7 == 7'd0 || (f3[2] && f7 == 7'h20));
  assign sh32_ok = f7 == 7'd0 || (f3[2] && f7 == 7'h20);
  assign r_ok    = f7 == 7'd0 || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)) || (f7 == 7'd1 && HAS_M);

  always_comb begin
    legal    = 1'b0;
    ebrk     = 1'b0;
    is_m     = 1'b0;
    is_ld    = 1'b0;
    is_st    = 1'b0;
    is_br    = 1'b0;
    is_jal   = 1'b0;
    is_jalr  = 1'b0;
    is_fence = 1'b0;
    imm_sel  = 3'd0;
    alu_sel  = 5'd0;
    word     = 1'b0;
    a_pc     = 1'b0;
    b_imm    = 1'b0;
    wb_sel   = 2'd0;
    case (op)
      OP_LUI:   begin legal = 1'b1; imm_sel = 3'd4; alu_sel = 5'b01111; b_imm = 1'b1; end
      OP_AUIPC: begin legal = 1'b1; imm_sel = 3'd4; a_pc = 1'b1; b_imm = 1'b1; end
      OP_JAL:   begin legal = 1'b1; imm_sel = 3'd5; a_pc = 1'b1; b_imm = 1'b1; wb_sel = 2'd2; is_jal = 1'b1; end
      OP_JALR:  begin legal = 1'b1; imm_sel = 3'd1; b_imm = 1'b1; wb_sel = 2'd2; is_jalr = 1'b1; end
      OP_BR:    begin legal = 1'b1; imm_sel = 3'd3; alu_sel = {2'b01, f3}; is_br = 1'b1; end
      OP_LD:    begin legal = 1'b1; imm_sel = 3'd1; b_imm = 1'b1; wb_sel = 2'd1; is_ld = 1'b1; end
      OP_ST:    begin legal = 1'b1; imm_sel = 3'd2; b_imm = 1'b1; is_st = 1'b1; end
      OP_IMM: begin
        legal   = !shift || sh_ok;
        imm_sel = 3'd1;
        b_imm   = 1'b1;
        alu_sel = {1'b0, shift & ir_q[30], f3};
      end
      OP_IMM32: begin
        legal   = RV64 && (!shift || sh32_ok);
        imm_sel = 3'd1;
        b_imm   = 1'b1;
        word    = 1'b1;
        alu_sel = {1'b0, shift & ir_q[30], f3};
      end
      OP_REG: begin
        legal   = r_ok;
        is_m    = f7 == 7'd1;
        alu_sel = {is_m, ir_q[30], f3};
      end
      OP_REG32: begin
        legal   = RV64 && r_ok;
        is_m    = f7 == 7'd1;
        word    = 1'b1;
        alu_sel = {is_m, ir_q[30], f3};
      end
      OP_FENCE: begin legal = 1'b1; is_fence = 1'b1; end
      OP_SYS:   ebrk = ir_q == EBREAK;
      default:  ;
    endcase
  end

  // M ops finish only on an alu_done seen after the start pulse has gone out
  assign exec_done = !is_m || (started_q && bus.alu_done);

  always_comb begin
    state_d   = state_q;
    ir_d      = ir_q;
    br_d      = br_q;
    illegal_d = illegal_q;
    started_d = 1'b0;
    case (state_q)
      FETCH: if (bus.inst_valid) begin
        ir_d    = bus.inst;
        state_d = DECODE;
      end
      DECODE: begin
        state_d   = legal ? EXEC : TRAP;
        illegal_d = !legal && !ebrk;
      end
      EXEC: begin
        br_d      = bus.br_taken;
        started_d = is_m && !exec_done;
        state_d   = !exec_done ? EXEC : (is_ld || is_st) ? MEM : WB;
      end
      MEM:     state_d = !bus.mem_ack ? MEM : is_st ? FETCH : WB;
      WB:      state_d = FETCH;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= FETCH;
      ir_q      <= '0;
      br_q      <= 1'b0;
      illegal_q <= 1'b0;
      started_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ir_q      <= ir_d;
      br_q      <= br_d;
      illegal_q <= illegal_d;
      started_q <= started_d;
    end
  end

  // decode outputs are only driven while an accepted, legal instruction is in flight
  assign dec_en = legal && (state_q == DECODE || state_q == EXEC || state_q == MEM || state_q == WB);

  assign bus.inst_ready = state_q == FETCH;
  assign bus.immsel     = dec_en ? imm_sel : 3'd0;
  assign bus.alusel     = dec_en ? alu_sel : 5'd0;
  assign bus.alu_word   = dec_en && word;
  assign bus.asel       = dec_en && a_pc;
  assign bus.bsel       = dec_en && b_imm;
  assign bus.mem_size   = (dec_en && (is_ld || is_st)) ? f3 : 3'd0;
  assign bus.wbsel      = dec_en ? wb_sel : 2'd0;
  assign bus.alu_start  = state_q == EXEC && is_m && !started_q;
  assign bus.mem_req    = state_q == MEM;
  assign bus.mem_we     = state_q == MEM && is_st;
  assign bus.regwen     = state_q == WB && ir_q[11:7] != 5'd0 && !is_br && !is_fence;
  assign bus.pc_wen     = state_q == WB || (state_q == MEM && is_st && bus.mem_ack);
  assign bus.pc_sel     = state_q != WB ? 2'd0 : is_jal ? 2'd1 : is_jalr ? 2'd2 : (is_br && br_q) ? 2'd1 : 2'd0;
  assign bus.halt       = state_q == TRAP;
  assign bus.illegal    = illegal_q;
endmodule

// File: tb/tb_ysyx_22040759_ctrl_fsm.sv
// tb_ysyx_22040759_ctrl_fsm: randomized cycle-trace scoreboard for the control FSM plus directed XLEN=32/HAS_M=0 checks
module tb_ysyx_22040759_ctrl_fsm;
  localparam logic [31:0] ADDI  = 32'h0050_0093;
  localparam logic [31:0] LW    = 32'h0000_A103;
  localparam logic [31:0] SW    = 32'h0020_A223;
  localparam logic [31:0] MUL   = 32'h0220_81B3;
  localparam logic [31:0] ADDW  = 32'h0020_80BB;
  localparam logic [31:0] EBRK  = 32'h0010_0073;

  typedef struct packed {
    logic       legal, ebrk, m, ld, st, br, jal, jalr, fence, rdnz;
    logic [2:0] imm;
    logic [4:0] alu;
    logic       word, asel, bsel;
    logic [2:0] msz;
    logic [1:0] wb;
  } dec_t;
  typedef logic [25:0] ov_t;

  logic clk = 1'b0;
  logic rst_a = 1'b1;
  logic rst_b = 1'b1;
  int total = 0;
  int bad = 0;
  ov_t exp_q[$];
  int  ph_q[$];
  ov_t a_out;

  always #5 clk = ~clk;

  ysyx_22040759_ctrl_fsm_if ia ();
  ysyx_22040759_ctrl_fsm_if ib ();
  ysyx_22040759_ctrl_fsm dut_a (.clk(clk), .rst(rst_a), .bus(ia));
  ysyx_22040759_ctrl_fsm #(.XLEN(32), .HAS_M(1'b0)) dut_b (.clk(clk), .rst(rst_b), .bus(ib));

  assign a_out = {ia.inst_ready, ia.immsel, ia.alusel, ia.alu_word, ia.alu_start, ia.asel, ia.bsel,
                  ia.mem_req, ia.mem_we, ia.mem_size, ia.wbsel, ia.regwen, ia.pc_wen, ia.pc_sel,
                  ia.halt, ia.illegal};

  function automatic dec_t dec(input logic [31:0] i, input bit x64, input bit hm);
    dec_t d;
    logic [6:0] f7;
    logic [2:0] f3;
    bit sh, rok, e;
    d  = '0;
    f7 = i[31:25];
    f3 = i[14:12];
    sh = f3 == 3'd1 || f3 == 3'd5;
    rok = f7 == 7'd0 || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)) || (f7 == 7'd1 && hm);
    d.rdnz = i[11:7] != 5'd0;
    case (i[6:0])
      7'h37: begin d.legal = 1; d.imm = 4; d.alu = 5'd15; d.bsel = 1; end
      7'h17: begin d.legal = 1; d.imm = 4; d.asel = 1; d.bsel = 1; end
      7'h6F: begin d.legal = 1; d.imm = 5; d.asel = 1; d.bsel = 1; d.wb = 2; d.jal = 1; end
      7'h67: begin d.legal = 1; d.imm = 1; d.bsel = 1; d.wb = 2; d.jalr = 1; end
      7'h63: begin d.legal = 1; d.imm = 3; d.alu = 5'd8 + 5'(f3); d.br = 1; end
      7'h03: begin d.legal = 1; d.imm = 1; d.bsel = 1; d.msz = f3; d.wb = 1; d.ld = 1; end
      7'h23: begin d.legal = 1; d.imm = 2; d.bsel = 1; d.msz = f3; d.st = 1; end
      7'h13: begin
        d.legal = !sh || (x64 ? (i[31:26] == 6'd0 || (f3 == 3'd5 && i[31:26] == 6'h10))
                              : (f7 == 7'd0 || (f3 == 3'd5 && f7 == 7'h20)));
        d.imm = 1; d.bsel = 1; d.alu = (sh && i[30]) ? 5'd8 + 5'(f3) : 5'(f3);
      end
      7'h1B: begin
        d.legal = x64 && (!sh || f7 == 7'd0 || (f3 == 3'd5 && f7 == 7'h20));
        d.imm = 1; d.bsel = 1; d.word = 1; d.alu = (sh && i[30]) ? 5'd8 + 5'(f3) : 5'(f3);
      end
      7'h33, 7'h3B: begin
        d.legal = rok && (i[6:0] == 7'h33 || x64);
        d.m = f7 == 7'd1;
        d.word = i[6:0] == 7'h3B;
        d.alu = 5'(f3) + (i[30] ? 5'd8 : 5'd0) + (d.m ? 5'd16 : 5'd0);
      end
      7'h0F: begin d.legal = 1; d.fence = 1; end
      7'h73: d.ebrk = i == 32'h0010_0073;
      default: ;
    endcase
    if (!d.legal) begin
      e = d.ebrk;
      d = '0;
      d.ebrk = e;
    end
    return d;
  endfunction

  function automatic ov_t mk(input logic rdy, input dec_t d, input logic st, input logic rq, input logic we,
                             input logic rw, input logic pw, input logic [1:0] ps, input logic h, input logic il);
    return {rdy, d.imm, d.alu, d.word, st, d.asel, d.bsel, rq, we, d.msz, d.wb, rw, pw, ps, h, il};
  endfunction

  function automatic string ph_name(input int p);
    case (p)
      1: return "fetch";
      2: return "decode";
      3: return "exec";
      4: return "mem";
      5: return "wb";
      6: return "trap";
      default: return "reset";
    endcase
  endfunction

  function automatic logic nz();
    return $urandom_range(0, 3) == 0;
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, got, want);
    end
  endtask

  always @(negedge clk) begin
    #1;
    if (exp_q.size() != 0) begin
      ov_t e;
      int p;
      e = exp_q.pop_front();
      p = ph_q.pop_front();
      if (p != 0) begin
        total++;
        if (a_out !== e) begin
          bad++;
          $display("FAIL %s: got %h want %h", ph_name(p), a_out, e);
        end
      end
    end
  end

  task automatic step(input logic iv, input logic [31:0] w, input logic bt, input logic ad, input logic ma,
                      input logic r, input ov_t e, input int ph);
    @(negedge clk);
    ia.inst_valid = iv;
    ia.inst = w;
    ia.br_taken = bt;
    ia.alu_done = ad;
    ia.mem_ack = ma;
    rst_a = r;
    exp_q.push_back(e);
    ph_q.push_back(ph);
  endtask

  task automatic run(input logic [31:0] w, input int k, input int m, input bit mid_rst);
    dec_t d;
    logic bt;
    logic [1:0] ps;
    ov_t idle, tv, xv, mv;
    d = dec(w, 1'b1, 1'b1);
    idle = mk(1'b1, '0, 0, 0, 0, 0, 0, 2'd0, 0, 0);
    xv = mk(1'b0, d, 0, 0, 0, 0, 0, 2'd0, 0, 0);
    mv = mk(1'b0, d, 0, 1, d.st, 0, 0, 2'd0, 0, 0);
    repeat ($urandom_range(0, 2)) step(1'b0, $urandom, nz(), nz(), nz(), 1'b0, idle, 1);
    step(1'b1, w, nz(), nz(), nz(), 1'b0, idle, 1);
    step(nz(), $urandom, nz(), nz(), nz(), 1'b0, xv, 2);
    if (!d.legal) begin
      tv = mk(1'b0, '0, 0, 0, 0, 0, 0, 2'd0, 1'b1, !d.ebrk);
      repeat (20) step(1'b1, $urandom, nz(), nz(), nz(), 1'b0, tv, 6);
      step(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1, tv, 7);
      return;
    end
    bt = nz();
    if (d.m) begin
      step(nz(), $urandom, bt, 1'b0, nz(), 1'b0, mk(1'b0, d, 1, 0, 0, 0, 0, 2'd0, 0, 0), 3);
      for (int j = 1; j < k; j++) begin
        if (mid_rst && $urandom_range(0, 3) == 0) begin
          step(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1, xv, 7);
          return;
        end
        step(nz(), $urandom, bt, 1'b0, nz(), 1'b0, xv, 3);
      end
      step(nz(), $urandom, bt, 1'b1, nz(), 1'b0, xv, 3);
    end else
      step(nz(), $urandom, bt, nz(), nz(), 1'b0, xv, 3);
    if (d.ld || d.st) begin
      for (int j = 0; j < m; j++) begin
        if (mid_rst && $urandom_range(0, 3) == 0) begin
          step(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1, mv, 7);
          return;
        end
        step(nz(), $urandom, nz(), nz(), 1'b0, 1'b0, mv, 4);
      end
      step(nz(), $urandom, nz(), nz(), 1'b1, 1'b0, mk(1'b0, d, 0, 1, d.st, 0, d.st, 2'd0, 0, 0), 4);
      if (d.st) return;
    end
    ps = d.jal ? 2'd1 : d.jalr ? 2'd2 : (d.br && bt) ? 2'd1 : 2'd0;
    step(nz(), $urandom, nz(), nz(), nz(), 1'b0,
         mk(1'b0, d, 0, 0, 0, d.rdnz && !d.br && !d.fence, 1'b1, ps, 0, 0), 5);
  endtask

  function automatic logic [31:0] rand_inst();
    logic [31:0] w;
    logic [6:0] ops [0:11];
    logic [6:0] f7s [0:2];
    int s;
    ops = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33, 7'h1B, 7'h3B, 7'h0F};
    f7s = '{7'h00, 7'h20, 7'h01};
    w = $urandom;
    s = $urandom_range(0, 15);
    if (s < 12) w[6:0] = ops[s];
    else if (s < 14) w[6:0] = 7'h33;
    else if (s == 14) w = 32'h0010_0073;
    if ((w[6:0] == 7'h33 || w[6:0] == 7'h3B || w[6:0] == 7'h13 || w[6:0] == 7'h1B) && $urandom_range(0, 3) != 0)
      w[31:25] = f7s[$urandom_range(0, 2)];
    return w;
  endfunction

  task automatic bstep(input logic iv, input logic [31:0] w);
    @(negedge clk);
    ib.inst_valid = iv;
    ib.inst = w;
    #1;
  endtask

  task automatic brst();
    @(negedge clk);
    rst_b = 1'b1;
    ib.inst_valid = 1'b0;
    @(negedge clk);
    rst_b = 1'b0;
    #1;
    chk("b_reset", {ib.halt, ib.illegal, ib.inst_ready}, 32'b001);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    dec_t d;
    {ia.inst_valid, ia.inst, ia.br_taken, ia.alu_done, ia.mem_ack} = '0;
    {ib.inst_valid, ib.inst, ib.br_taken, ib.alu_done, ib.mem_ack} = '0;
    d = dec(ADDI, 1, 1);
    chk("pin_addi", {d.legal, d.imm, d.alu, d.bsel, d.wb}, {1'b1, 3'd1, 5'd0, 1'b1, 2'd0});
    d = dec(LW, 1, 1);
    chk("pin_lw", {d.legal, d.imm, d.msz, d.wb, d.ld}, {1'b1, 3'd1, 3'd2, 2'd1, 1'b1});
    d = dec(SW, 1, 1);
    chk("pin_sw", {d.legal, d.imm, d.st, d.msz}, {1'b1, 3'd2, 1'b1, 3'd2});
    d = dec(MUL, 1, 1);
    chk("pin_mul", {d.legal, d.m, d.alu}, {1'b1, 1'b1, 5'b10000});
    d = dec(MUL, 1, 0);
    chk("pin_mul_nom", {d.legal, d.ebrk}, 32'b00);
    d = dec(ADDW, 1, 1);
    chk("pin_addw64", {d.legal, d.word}, 32'b11);
    d = dec(ADDW, 0, 1);
    chk("pin_addw32", d.legal, 32'b0);
    d = dec(EBRK, 1, 1);
    chk("pin_ebreak", {d.legal, d.ebrk}, 32'b01);
    step(1'b0, '0, 0, 0, 0, 1'b1, '0, 0);
    step(1'b0, '0, 0, 0, 0, 1'b1, '0, 0);
    run(ADDI, 1, 0, 0);
    run(LW, 1, 3, 0);
    run(SW, 1, 0, 0);
    run(MUL, 4, 0, 0);
    run(ADDW, 1, 0, 0);
    run(EBRK, 1, 0, 0);
    for (int i = 0; i < 400; i++)
      run(rand_inst(), $urandom_range(1, 5), $urandom_range(0, 3), $urandom_range(0, 4) == 0);
    step(1'b0, '0, 0, 0, 0, 1'b0, mk(1'b1, '0, 0, 0, 0, 0, 0, 2'd0, 0, 0), 1);
    brst();
    bstep(1'b1, ADDI);
    chk("b_addi_acc", ib.inst_ready, 32'd1);
    bstep(1'b0, '0);
    chk("b_addi_dec", {ib.immsel, ib.bsel, ib.regwen}, {3'd1, 1'b1, 1'b0});
    bstep(1'b0, '0);
    chk("b_addi_exec", {ib.regwen, ib.pc_wen}, 32'b00);
    bstep(1'b0, '0);
    chk("b_addi_wb", {ib.regwen, ib.pc_wen}, 32'b11);
    bstep(1'b0, '0);
    chk("b_addi_next", {ib.inst_ready, ib.regwen, ib.pc_wen}, 32'b100);
    bstep(1'b1, MUL);
    bstep(1'b0, '0);
    chk("b_mul_dec", ib.halt, 32'd0);
    bstep(1'b0, '0);
    chk("b_mul_trap", {ib.halt, ib.illegal}, 32'b11);
    repeat (20) begin
      bstep(1'b1, ADDI);
      chk("b_mul_hold", {ib.halt, ib.illegal, ib.inst_ready, ib.regwen, ib.pc_wen}, 32'b11000);
    end
    brst();
    bstep(1'b1, ADDW);
    bstep(1'b0, '0);
    bstep(1'b0, '0);
    chk("b_addw_trap", {ib.halt, ib.illegal}, 32'b11);
    brst();
    bstep(1'b1, EBRK);
    bstep(1'b0, '0);
    bstep(1'b0, '0);
    chk("b_ebreak", {ib.halt, ib.illegal}, 32'b10);
    brst();
    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/ysyx_22040759_ctrl_fsm.md
# ysyx_22040759_ctrl_fsm

Multi-cycle control unit for the ysyx_22040759 core. It supersedes the single-cycle `addi`-only decoder. It accepts one instruction per handshake, decodes the full RV32I/RV64I base set (plus optional M extension), and sequences FETCH → DECODE → EXEC → MEM → WB. It drives the regfile, ALU, immediate generator and LSU control lines from a latched instruction. It sits between the IFU and the datapath, and halts the core on `ebreak` or an illegal instruction.

## Interface
Parameters:
- `XLEN`, 64: datapath width, 32 or 64. RV64 W-ops are legal only when 64.
- `HAS_M`, 1: 1 decodes M-extension ops as multi-cycle ALU ops; 0 makes them illegal.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `inst_valid` in 1: IFU offers `inst`.
- `inst` in 32: instruction word.
- `inst_ready` out 1: FSM accepts an instruction.
- `br_taken` in 1: ALU compare result, sampled in EXEC.
- `alu_done` in 1: multi-cycle (M) ALU result ready.
- `mem_ack` in 1: LSU completes the current request.
- `immsel` out 3: 0 none, 1 I, 2 S, 3 B, 4 U, 5 J.
- `alusel` out 5: ALU operation (encoding below).
- `alu_word` out 1: 32-bit W-op, sign-extend result.
- `alu_start` out 1: one-cycle pulse that starts an M op.
- `asel` out 1: 0 rs1, 1 pc.
- `bsel` out 1: 0 rs2, 1 imm.
- `mem_req` out 1: LSU request.
- `mem_we` out 1: store.
- `mem_size` out 3: funct3 of the load/store.
- `wbsel` out 2: 0 ALU, 1 mem, 2 pc+4.
- `regwen` out 1: regfile write strobe.
- `pc_wen` out 1: PC update strobe.
- `pc_sel` out 2: 0 pc+4, 1 pc+imm, 2 (rs1+imm)&~1.
- `halt` out 1: sticky stop.
- `illegal` out 1: sticky, set when the halt cause was an illegal instruction.

## Operation
- States: FETCH, DECODE, EXEC, MEM, WB, TRAP.
- **FETCH:** `inst_ready`=1.
  - `inst_valid` in the same cycle latches `inst` into `ir` and moves to DECODE.
- **DECODE:** one cycle. Decode fields from `ir`.
  - Illegal instruction → TRAP with `illegal`=1.
  - `ebreak` (0x00100073) → TRAP with `illegal`=0.
  - Everything else → EXEC.
- **Illegal instructions:**
  - unknown opcode;
  - OP-32/OP-IMM-32 when XLEN=32;
  - funct7=0000001 when HAS_M=0;
  - SYSTEM other than `ebreak`;
  - bad funct7 on R-type or shifts.
  - FENCE is legal and acts as a no-op (WB with `regwen`=0).
- **`alusel` encoding:**
  - R-type and shift-imm: {is_M, ir[30], funct3}.
  - Other OP-IMM: {0, 0, funct3}.
  - LUI: 5'b01111, meaning pass B.
  - AUIPC, JAL, JALR, loads, stores: 5'b00000 (ADD).
  - Branches: {0, 1, funct3} (compare).
- **Decode outputs** are combinational from `ir`. They are held stable from DECODE through WB/MEM.
- **EXEC:**
  - M op: `alu_start` pulses in the first EXEC cycle, then the FSM waits for `alu_done`.
  - Otherwise EXEC lasts one cycle.
  - Branch: `br_taken` is latched.
  - Next state is MEM for loads/stores, WB otherwise.
- **MEM:** `mem_req`=1 (and `mem_we` for stores) held until `mem_ack`.
  - Load → WB.
  - Store: `pc_wen`=1 in the `mem_ack` cycle, then FETCH.
- **WB:** one cycle. `pc_wen`=1.
  - `regwen`=1 unless rd=x0, branch, store or FENCE.
  - `pc_sel`: JAL 1, JALR 2, taken branch 1, else 0.
  - Next state FETCH.
- **TRAP:** `halt`=1. Absorbing until `rst`. `inst_ready`, `regwen`, `pc_wen` and `mem_req` stay 0.

## Timing
- **Reset:** state FETCH, `ir`=0.
  - All outputs 0, except that `inst_ready`=1 in the first cycle after reset.
  - `halt`=0, `illegal`=0.
- **Reset mid-operation:** an outstanding `mem_req` or ALU wait is abandoned; late `mem_ack`/`alu_done` are ignored in FETCH.
- **Latency**, with accept in cycle N:
  - ALU op: DECODE N+1, EXEC N+2, WB N+3, `inst_ready` N+4.
  - Load with immediate `mem_ack`: MEM N+3, WB N+4.
  - Store with immediate ack: done at N+3.
  - M op with `alu_done` k cycles after `alu_start`: WB at N+3+k.
- **Simultaneous events:**
  - `mem_ack` and `alu_done` outside their states are ignored.
  - `inst_valid` outside FETCH is ignored; the IFU must hold the instruction.
- **Strobes:**
  - `regwen` and `pc_wen` are high for exactly one cycle per instruction.
  - `mem_req` stays high through every MEM cycle.

## Test plan
- `addi x1,x0,5` (0x00500093) accepted at N → `immsel`=1, `alusel`=0, `bsel`=1, `wbsel`=0; `regwen`=`pc_wen`=1 only at N+3; `inst_ready` high at N+4.
- `lw x2,0(x1)` (0x0000A103) with `mem_ack` delayed 3 cycles → `mem_req` high at N+3..N+6 with `mem_we`=0 and `mem_size`=2; WB at N+7 with `wbsel`=1.
- `sw x2,4(x1)` (0x0020A223), ack at N+3 → `immsel`=2, `mem_we`=1, `pc_wen` at N+3, `regwen` never asserted.
- `mul x3,x1,x2` (0x022081B3), HAS_M=1, `alu_done` at N+6 → `alu_start` pulses at N+2 only, `alusel`=5'b10000, WB at N+7. With HAS_M=0 → `halt`=`illegal`=1 from N+2.
- `addw x1,x1,x2` (0x002080BB): XLEN=64 → `alu_word`=1. XLEN=32 → TRAP with `illegal`=1.
- `ebreak` (0x00100073) → `halt`=1, `illegal`=0, held for 20 cycles despite `inst_valid`; `rst` pulse → FETCH with `halt`=0.
